// File: rtl/param_cache_controller.sv
// Write-back, write-allocate set-associative cache controller (1 or 2 ways)
// sitting between a single-word CPU port and a line-wide memory port.
module param_cache_controller #(
  parameter  int SETS       = 1024,
  parameter  int WAYS       = 2,
  parameter  int LINE_WORDS = 4,
  localparam int LINE_BITS  = 32 * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_rw,
  input  logic [31:0]          cpu_req_addr,
  input  logic [31:0]          cpu_req_data,
  output logic [31:0]          cpu_resp_data,
  output logic                 cpu_resp_ready,
  output logic [31:0]          mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_data,
  output logic                 mem_req_rw,
  output logic                 mem_req_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data,
  input  logic                 mem_resp_ready,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] COMPARE    = 2'd1;
  localparam logic [1:0] WRITE_BACK = 2'd2;
  localparam logic [1:0] ALLOCATE   = 2'd3;

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int WSEL_W = (OFF_W > 0) ? OFF_W : 1;

  logic [1:0]  state;
  logic        req_rw;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        first_cmp;
  logic        victim_q;

  logic [SETS-1:0]      valid_q [WAYS];
  logic [SETS-1:0]      dirty_q [WAYS];
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_mem  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_mem [WAYS][SETS];

  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;

  assign req_index = req_addr[2+OFF_W +: IDX_W];
  assign req_tag   = req_addr[31 -: TAG_W];

  generate
    if (OFF_W > 0) begin : g_word
      assign req_word = req_addr[2 +: WSEL_W];
    end else begin : g_single
      assign req_word = '0;
    end
  endgenerate

  logic [WAYS-1:0]      way_hit;
  logic                 hit;
  logic                 hit_way;
  logic                 victim_c;
  logic                 victim_dirty;
  logic [LINE_BITS-1:0] hit_line;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++)
      way_hit[w] = valid_q[w][req_index] && (tag_mem[w][req_index] == req_tag);
    hit      = |way_hit;
    hit_way  = (WAYS == 2) && way_hit[WAYS-1];
    hit_line = data_mem[hit_way][req_index];

    // Fill an empty way before evicting; only then fall back to LRU.
    if (!valid_q[0][req_index])
      victim_c = 1'b0;
    else if ((WAYS == 2) && !valid_q[WAYS-1][req_index])
      victim_c = 1'b1;
    else
      victim_c = (WAYS == 2) && lru_q[req_index];
    victim_dirty = valid_q[victim_c][req_index] && dirty_q[victim_c][req_index];
  end

  always_comb begin
    cpu_resp_ready = 1'b0;
    cpu_resp_data  = '0;
    mem_req_valid  = 1'b0;
    mem_req_rw     = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    case (state)
      COMPARE: begin
        if (hit) begin
          cpu_resp_ready = 1'b1;
          if (!req_rw) cpu_resp_data = hit_line[32*req_word +: 32];
        end
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_mem[victim_q][req_index], req_index, {(OFF_W+2){1'b0}}};
        mem_req_data  = data_mem[victim_q][req_index];
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index, {(OFF_W+2){1'b0}}};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_rw     <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      first_cmp  <= 1'b0;
      victim_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      lru_q      <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_rw    <= cpu_req_rw;
            req_addr  <= cpu_req_addr;
            req_data  <= cpu_req_data;
            first_cmp <= 1'b1;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            if (req_rw) dirty_q[hit_way][req_index] <= 1'b1;
            if (WAYS == 2) lru_q[req_index] <= ~hit_way;
            if (first_cmp && (hit_count != '1)) hit_count <= hit_count + 32'd1;
            state <= IDLE;
          end else begin
            victim_q <= victim_c;
            if (first_cmp && (miss_count != '1)) miss_count <= miss_count + 32'd1;
            state <= victim_dirty ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: begin
          if (mem_resp_ready) begin
            dirty_q[victim_q][req_index] <= 1'b0;
            state <= ALLOCATE;
          end
        end
        default: begin
          if (mem_resp_ready) begin
            valid_q[victim_q][req_index] <= 1'b1;
            dirty_q[victim_q][req_index] <= 1'b0;
            first_cmp <= 1'b0;
            state     <= COMPARE;
          end
        end
      endcase
    end
  end

  // NOTE: tag/data arrays are not reset (valid bits guard them); writes are only blocked during reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state == COMPARE) && hit && req_rw)
        data_mem[hit_way][req_index][32*req_word +: 32] <= req_data;
      if ((state == ALLOCATE) && mem_resp_ready) begin
        data_mem[victim_q][req_index] <= mem_resp_data;
        tag_mem[victim_q][req_index]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_param_cache_controller.sv
// Directed bench: 2-way/4-word cache (instance a) and direct-mapped/8-word cache (instance b).
module tb_param_cache_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         a_req_valid, a_req_rw, a_resp_ready, a_mem_rw, a_mem_valid, a_mem_resp_ready;
  logic [31:0]  a_req_addr, a_req_data, a_resp_data, a_mem_addr, a_hits, a_misses;
  logic [127:0] a_mem_data, a_mem_resp_data;

  logic         b_req_valid, b_req_rw, b_resp_ready, b_mem_rw, b_mem_valid, b_mem_resp_ready;
  logic [31:0]  b_req_addr, b_req_data, b_resp_data, b_mem_addr, b_hits, b_misses;
  logic [255:0] b_mem_data, b_mem_resp_data;

  param_cache_controller dut_a (
    .clk(clk), .reset(reset),
    .cpu_req_valid(a_req_valid), .cpu_req_rw(a_req_rw),
    .cpu_req_addr(a_req_addr), .cpu_req_data(a_req_data),
    .cpu_resp_data(a_resp_data), .cpu_resp_ready(a_resp_ready),
    .mem_req_addr(a_mem_addr), .mem_req_data(a_mem_data),
    .mem_req_rw(a_mem_rw), .mem_req_valid(a_mem_valid),
    .mem_resp_data(a_mem_resp_data), .mem_resp_ready(a_mem_resp_ready),
    .hit_count(a_hits), .miss_count(a_misses)
  );

  param_cache_controller #(.WAYS(1), .LINE_WORDS(8)) dut_b (
    .clk(clk), .reset(reset),
    .cpu_req_valid(b_req_valid), .cpu_req_rw(b_req_rw),
    .cpu_req_addr(b_req_addr), .cpu_req_data(b_req_data),
    .cpu_resp_data(b_resp_data), .cpu_resp_ready(b_resp_ready),
    .mem_req_addr(b_mem_addr), .mem_req_data(b_mem_data),
    .mem_req_rw(b_mem_rw), .mem_req_valid(b_mem_valid),
    .mem_resp_data(b_mem_resp_data), .mem_resp_ready(b_mem_resp_ready),
    .hit_count(b_hits), .miss_count(b_misses)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_start(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    a_req_rw = rw; a_req_addr = addr; a_req_data = data; a_req_valid = 1'b1;
    step();
  endtask

  task automatic a_end();
    step();
    a_req_valid = 1'b0;
  endtask

  task automatic a_fill(input logic [127:0] line);
    a_mem_resp_data = line; a_mem_resp_ready = 1'b1;
    step();
    a_mem_resp_ready = 1'b0; a_mem_resp_data = '0;
  endtask

  task automatic b_start(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    b_req_rw = rw; b_req_addr = addr; b_req_data = data; b_req_valid = 1'b1;
    step();
  endtask

  task automatic b_end();
    step();
    b_req_valid = 1'b0;
  endtask

  task automatic b_fill(input logic [255:0] line);
    b_mem_resp_data = line; b_mem_resp_ready = 1'b1;
    step();
    b_mem_resp_ready = 1'b0; b_mem_resp_data = '0;
  endtask

  initial begin
    int bad;
    a_req_valid = 0; a_req_rw = 0; a_req_addr = 0; a_req_data = 0;
    a_mem_resp_ready = 0; a_mem_resp_data = '0;
    b_req_valid = 0; b_req_rw = 0; b_req_addr = 0; b_req_data = 0;
    b_mem_resp_ready = 0; b_mem_resp_data = '0;
    reset = 1'b1;
    step();
    step();
    check("rst_resp_ready", a_resp_ready, 0);
    check("rst_resp_data", a_resp_data, 0);
    check("rst_mem_valid", a_mem_valid, 0);
    check("rst_counts", {a_hits, a_misses}, 0);
    check("rst_b_mem_valid", b_mem_valid, 0);
    reset = 1'b0;

    // Cold read miss of 0x1004.
    a_start(0, 32'h1004, 0);
    check("miss_cmp_ready", a_resp_ready, 0);
    check("miss_cmp_mem_valid", a_mem_valid, 0);
    step();
    check("fill1_valid", a_mem_valid, 1);
    check("fill1_rw", a_mem_rw, 0);
    check("fill1_addr", a_mem_addr, 32'h1000);
    check("fill1_data", a_mem_data, 0);
    a_fill({32'h13, 32'h12, 32'h11, 32'h10});
    check("fill1_resp_ready", a_resp_ready, 1);
    check("fill1_resp_data", a_resp_data, 32'h11);
    a_end();
    check("miss_count1", a_misses, 1);
    check("hit_count0", a_hits, 0);

    // Read hit, one-cycle latency.
    a_start(0, 32'h1004, 0);
    check("hit_ready", a_resp_ready, 1);
    check("hit_data", a_resp_data, 32'h11);
    check("hit_no_mem", a_mem_valid, 0);
    a_end();
    check("hit_count1", a_hits, 1);

    // Write hit; response data must be zero.
    a_start(1, 32'h1008, 32'hDEADBEEF);
    check("whit_ready", a_resp_ready, 1);
    check("whit_data", a_resp_data, 0);
    a_end();
    check("hit_count2", a_hits, 2);

    // Miss on 0x5000 fills way 1; memory stalls 10 cycles.
    a_start(0, 32'h5000, 0);
    step();
    check("fill2_addr", a_mem_addr, 32'h5000);
    bad = 0;
    repeat (10) begin
      step();
      if (a_mem_valid !== 1'b1 || a_mem_rw !== 1'b0 || a_mem_addr !== 32'h5000 || a_resp_ready !== 1'b0)
        bad++;
    end
    check("alloc_hold", bad, 0);
    a_fill({32'h53, 32'h52, 32'h51, 32'h50});
    check("fill2_resp_data", a_resp_data, 32'h50);
    a_end();
    check("miss_count2", a_misses, 2);

    // Miss on 0x9000 evicts dirty way 0 (tag 0).
    a_start(0, 32'h9000, 0);
    step();
    check("wb_valid", a_mem_valid, 1);
    check("wb_rw", a_mem_rw, 1);
    check("wb_addr", a_mem_addr, 32'h1000);
    check("wb_data", a_mem_data, {32'h13, 32'hDEADBEEF, 32'h11, 32'h10});
    a_fill('0);
    check("fill3_rw", a_mem_rw, 0);
    check("fill3_addr", a_mem_addr, 32'h9000);
    a_fill({32'h93, 32'h92, 32'h91, 32'h90});
    check("fill3_resp_ready", a_resp_ready, 1);
    check("fill3_resp_data", a_resp_data, 32'h90);
    a_end();
    check("miss_count3", a_misses, 3);

    // 0x5000 still resident in way 1.
    a_start(0, 32'h5000, 0);
    check("hit5000_ready", a_resp_ready, 1);
    check("hit5000_data", a_resp_data, 32'h50);
    check("hit5000_no_mem", a_mem_valid, 0);
    a_end();
    check("hit_count3", a_hits, 3);

    // Reset during ALLOCATE abandons the fill.
    a_start(0, 32'h2000, 0);
    step();
    check("fill4_addr", a_mem_addr, 32'h2000);
    a_req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_alloc_mem_valid", a_mem_valid, 0);
    check("rst_alloc_counts", {a_hits, a_misses}, 0);
    check("rst_alloc_ready", a_resp_ready, 0);
    a_start(0, 32'h2000, 0);
    check("post_rst_miss", a_resp_ready, 0);
    step();
    check("post_rst_fill_addr", a_mem_addr, 32'h2000);
    a_fill({32'h23, 32'h22, 32'h21, 32'h20});
    check("post_rst_data", a_resp_data, 32'h20);
    a_end();
    check("post_rst_miss_count", a_misses, 1);

    // Direct-mapped, 8-word lines: 0x0 and 0x8000 share index 0.
    b_start(0, 32'h0, 0);
    step();
    check("b_fill1_addr", b_mem_addr, 32'h0);
    check("b_fill1_rw", b_mem_rw, 0);
    b_fill({32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100});
    check("b_fill1_data", b_resp_data, 32'h100);
    b_end();
    b_start(1, 32'h4, 32'hCAFEF00D);
    check("b_whit_ready", b_resp_ready, 1);
    b_end();
    b_start(0, 32'h8000, 0);
    check("b_miss_ready", b_resp_ready, 0);
    step();
    check("b_wb_rw", b_mem_rw, 1);
    check("b_wb_addr", b_mem_addr, 32'h0);
    check("b_wb_data", b_mem_data,
          {32'h107, 32'h106, 32'h105, 32'h104, 32'h103, 32'h102, 32'hCAFEF00D, 32'h100});
    b_fill('0);
    check("b_fill2_rw", b_mem_rw, 0);
    check("b_fill2_addr", b_mem_addr, 32'h8000);
    b_fill({32'h207, 32'h206, 32'h205, 32'h204, 32'h203, 32'h202, 32'h201, 32'h200});
    check("b_fill2_data", b_resp_data, 32'h200);
    b_end();
    check("b_counts", {b_hits, b_misses}, {32'd1, 32'd2});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_cache_controller.md
PARAM_CACHE_CONTROLLER -- requirements
Module: param_cache_controller

Interface
REQ-001 Parameter SETS, default 1024, number of sets; power of two, >=2.
REQ-002 Parameter WAYS, default 2, associativity; legal values 1 and 2 only.
REQ-003 Parameter LINE_WORDS, default 4, 32-bit words per line; power of two, >=1. LINE_BITS = 32*LINE_WORDS.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req_valid  in  1; cpu_req_rw  in  1 (1=write); cpu_req_addr  in  32; cpu_req_data  in  32.
REQ-007 cpu_resp_data  out  32  read word; cpu_resp_ready  out  1  one-cycle completion pulse.
REQ-008 mem_req_addr  out  32; mem_req_data  out  LINE_BITS; mem_req_rw  out  1 (1=write); mem_req_valid  out  1.
REQ-009 mem_resp_data  in  LINE_BITS; mem_resp_ready  in  1  memory completion/data-valid.
REQ-010 hit_count  out  32; miss_count  out  32  saturating statistics.

Function
REQ-011 Address split: [1:0] byte (ignored), next log2(LINE_WORDS) bits word offset, next log2(SETS) bits index, remaining high bits tag.
REQ-012 Per set and way: valid, dirty, tag, LINE_BITS data; per set one LRU bit (WAYS=2 only; names least-recently-used way).
REQ-013 Write-back, write-allocate policy; states IDLE, COMPARE, WRITE_BACK, ALLOCATE.
REQ-014 IDLE: cpu_req_valid=1 accepts and latches rw/addr/data, next state COMPARE; CPU holds inputs stable until cpu_resp_ready and drops valid the following cycle unless issuing a new request.
REQ-015 COMPARE hit (any way valid with matching tag): cpu_resp_ready=1 this cycle; read drives selected word on cpu_resp_data; write updates selected word and sets dirty; LRU set to the other way; next IDLE.
REQ-016 Hit latency: accept cycle T, cpu_resp_ready at T+1; max throughput one request per 2 cycles.
REQ-017 COMPARE miss victim: lowest-numbered invalid way; else LRU way (way 0 when WAYS=1).
REQ-018 Miss with valid dirty victim -> WRITE_BACK; otherwise -> ALLOCATE.
REQ-019 WRITE_BACK: mem_req_valid=1, rw=1, addr={victim tag, index, zero offset}, data=victim line; on mem_resp_ready victim dirty cleared, next ALLOCATE.
REQ-020 ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, zero offset}, data=0; on mem_resp_ready line written to victim, valid=1, dirty=0, tag stored, next COMPARE (now hits).
REQ-021 mem_req_* stable while mem_req_valid=1 and mem_resp_ready=0; mem_resp_ready ignored outside WRITE_BACK/ALLOCATE.
REQ-022 cpu_resp_ready=0 and cpu_resp_data=0 in all cycles other than a COMPARE hit; cpu_resp_data=0 on write hits.
REQ-023 cpu_req_valid ignored outside IDLE.
REQ-024 miss_count +1 on COMPARE miss entered from IDLE; hit_count +1 on COMPARE hit entered from IDLE; post-allocate hit counts neither; both saturate at 0xFFFF_FFFF.
REQ-025 mem_req_valid and mem_req_rw are 0 in IDLE and COMPARE.

Reset
REQ-026 reset=1 at a clock edge: state IDLE, all valid/dirty/LRU bits 0, counters 0, latched request cleared; data arrays not cleared.
REQ-027 All outputs 0 in the cycle after reset is sampled, including mem_req_valid when reset interrupts WRITE_BACK or ALLOCATE; interrupted transaction abandoned, no line installed.
REQ-028 reset has priority over every other event in the same cycle.

Verification (defaults; 0x1000, 0x5000, 0x9000 share index 0x100, tags 0/1/2)
REQ-029 After reset, read 0x1004 -> mem_req read addr 0x1000 from T+2; respond line words {0x10,0x11,0x12,0x13} -> cpu_resp_ready with data 0x11 one cycle after mem_resp_ready; miss_count=1.
REQ-030 Repeat read 0x1004 -> cpu_resp_ready at T+1, data 0x11, no mem_req_valid, hit_count=1.
REQ-031 Write 0xDEADBEEF to 0x1008 (hit), read 0x5000 (fill way 1), read 0x9000 -> write-back addr 0x1000, word2=0xDEADBEEF, then read addr 0x9000; read 0x5000 afterwards hits.
REQ-032 Hold mem_resp_ready=0 for 10 cycles in ALLOCATE -> mem_req_addr/rw/valid unchanged, cpu_resp_ready=0 throughout.
REQ-033 Assert reset for one cycle during ALLOCATE -> next cycle mem_req_valid=0, counters 0; subsequent read of same address misses.
REQ-034 WAYS=1, LINE_WORDS=8: read 0x0, write 0x4, read 0x8000 (same index) -> dirty write-back of addr 0x0 precedes fill of addr 0x8000.
